// File: rtl/guess_game_ctrl.sv
// Two-player guess-number sequencer: secret/guess entry, positional compare,
// turn counting and sticky win/lose flags.
module guess_game_ctrl #(
    parameter int unsigned MIN_LEN   = 4,
    parameter int unsigned MAX_LEN   = 7,
    parameter int unsigned MAX_TURNS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       I1,
    input  logic       I2,
    input  logic       I3,
    input  logic       I4,
    input  logic       enter,
    output logic [2:0] state,
    output logic [3:0] numa,
    output logic [3:0] numb,
    output logic [3:0] turn,
    output logic [3:0] hits,
    output logic       result_valid,
    output logic       win,
    output logic       lose,
    output logic       equal,
    output logic       bigger,
    output logic       smaller,
    output logic       key_ack
);

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        COMPARE = 3'd2,
        DONE    = 3'd3
    } state_t;

    localparam logic [3:0] MIN_L   = 4'(MIN_LEN);
    localparam logic [3:0] LAST_L  = 4'(MAX_LEN - 1);
    localparam logic [3:0] TURNS_L = 4'(MAX_TURNS);

    state_t     cur, nxt;
    logic [1:0] secret [MAX_LEN];
    logic [1:0] guess  [MAX_LEN];
    logic       key;
    logic [1:0] sym;
    logic       store_a, store_b;
    logic [3:0] hit_cnt, min_len;
    logic       match, lose_now;

    always_comb begin
        key = I1 | I2 | I3 | I4;
        sym = 2'd3;
        if (I1)      sym = 2'd0;
        else if (I2) sym = 2'd1;
        else if (I3) sym = 2'd2;
    end

    // Only indices below the shorter length count, so stale guess entries
    // from an earlier turn never need clearing.
    always_comb begin
        hit_cnt = '0;
        min_len = (numa < numb) ? numa : numb;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (i < 32'(min_len) && secret[i] == guess[i]) hit_cnt = hit_cnt + 4'd1;
        end
        match    = (numa == numb) && (hit_cnt == numa);
        lose_now = (turn + 4'd1) == TURNS_L;
    end

    always_ff @(posedge clk) begin
        if (!reset) cur <= ENTER_A;
        else        cur <= nxt;
    end

    always_comb begin
        nxt     = cur;
        store_a = 1'b0;
        store_b = 1'b0;
        unique case (cur)
            ENTER_A: begin
                if (key) begin
                    store_a = 1'b1;
                    if (numa == LAST_L) nxt = ENTER_B;
                end else if (enter && numa >= MIN_L) begin
                    nxt = ENTER_B;
                end
            end
            ENTER_B: begin
                if (key) begin
                    store_b = 1'b1;
                    if (numb == LAST_L) nxt = COMPARE;
                end else if (enter && numb >= MIN_L) begin
                    nxt = COMPARE;
                end
            end
            COMPARE: nxt = (match || lose_now) ? DONE : ENTER_B;
            default: nxt = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (store_a && 32'(numa) == i) secret[i] <= sym;
            if (store_b && 32'(numb) == i) guess[i]  <= sym;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            numa         <= '0;
            numb         <= '0;
            turn         <= '0;
            hits         <= '0;
            result_valid <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
            equal        <= 1'b0;
            bigger       <= 1'b0;
            smaller      <= 1'b0;
            key_ack      <= 1'b0;
        end else begin
            key_ack      <= store_a | store_b;
            result_valid <= (cur == COMPARE);
            if (store_a) numa <= numa + 4'd1;
            if (store_b) numb <= numb + 4'd1;
            if (cur == COMPARE) begin
                hits    <= hit_cnt;
                equal   <= (numb == numa);
                bigger  <= (numb < numa);
                smaller <= (numb > numa);
                if (match) begin
                    win <= 1'b1;
                end else begin
                    turn <= turn + 4'd1;
                    if (lose_now) lose <= 1'b1;
                    else          numb <= '0;
                end
            end
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Self-checking bench for guess_game_ctrl: vector table, directed corner
// sequences and randomized play against a queue-based game model.
module tb_guess_game_ctrl;

    localparam int MIN_LEN   = 4;
    localparam int MAX_LEN   = 7;
    localparam int MAX_TURNS = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic I1 = 1'b0, I2 = 1'b0, I3 = 1'b0, I4 = 1'b0, enter = 1'b0;
    logic [2:0] state;
    logic [3:0] numa, numb, turn, hits;
    logic result_valid, win, lose, equal, bigger, smaller, key_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    guess_game_ctrl #(
        .MIN_LEN  (MIN_LEN),
        .MAX_LEN  (MAX_LEN),
        .MAX_TURNS(MAX_TURNS)
    ) dut (
        .clk(clk), .reset(reset),
        .I1(I1), .I2(I2), .I3(I3), .I4(I4), .enter(enter),
        .state(state), .numa(numa), .numb(numb), .turn(turn), .hits(hits),
        .result_valid(result_valid), .win(win), .lose(lose),
        .equal(equal), .bigger(bigger), .smaller(smaller), .key_ack(key_ack)
    );

    // Game model: phase 0=entering secret, 1=entering guess, 2=judging, 3=over.
    int         m_state, m_turn, m_hits;
    bit         m_win, m_lose, m_eq, m_big, m_sm, m_rv, m_ack;
    logic [1:0] sec_q[$];
    logic [1:0] gue_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [3:0] k, input bit en, input bit rst);
        int sym, n, h;
        if (!rst) begin
            m_state = 0; m_turn = 0; m_hits = 0;
            m_win = 0; m_lose = 0; m_eq = 0; m_big = 0; m_sm = 0; m_rv = 0; m_ack = 0;
            sec_q.delete(); gue_q.delete();
        end else begin
            m_rv = 0; m_ack = 0;
            sym = k[0] ? 0 : k[1] ? 1 : k[2] ? 2 : 3;
            case (m_state)
                0: if (k != 0) begin
                       sec_q.push_back(2'(sym)); m_ack = 1;
                       if (sec_q.size() == MAX_LEN) m_state = 1;
                   end else if (en && sec_q.size() >= MIN_LEN) m_state = 1;
                1: if (k != 0) begin
                       gue_q.push_back(2'(sym)); m_ack = 1;
                       if (gue_q.size() == MAX_LEN) m_state = 2;
                   end else if (en && gue_q.size() >= MIN_LEN) m_state = 2;
                2: begin
                    n = (sec_q.size() < gue_q.size()) ? sec_q.size() : gue_q.size();
                    h = 0;
                    for (int i = 0; i < n; i++) if (sec_q[i] == gue_q[i]) h++;
                    m_hits = h; m_rv = 1;
                    m_eq  = gue_q.size() == sec_q.size();
                    m_big = gue_q.size() <  sec_q.size();
                    m_sm  = gue_q.size() >  sec_q.size();
                    if (m_eq && h == sec_q.size()) begin
                        m_win = 1; m_state = 3;
                    end else begin
                        m_turn++;
                        if (m_turn == MAX_TURNS) begin m_lose = 1; m_state = 3; end
                        else begin gue_q.delete(); m_state = 1; end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        chk("state", state, m_state);
        chk("numa", numa, sec_q.size());
        chk("numb", numb, gue_q.size());
        chk("turn", turn, m_turn);
        chk("hits", hits, m_hits);
        chk("result_valid", result_valid, m_rv);
        chk("win", win, m_win);
        chk("lose", lose, m_lose);
        chk("equal", equal, m_eq);
        chk("bigger", bigger, m_big);
        chk("smaller", smaller, m_sm);
        chk("key_ack", key_ack, m_ack);
    endtask

    task automatic step(input logic [3:0] k, input bit en, input bit rst);
        {I4, I3, I2, I1} = k;
        enter = en;
        reset = rst;
        model_step(k, en, rst);
        @(posedge clk);
        #1;
        check_model();
        {I4, I3, I2, I1} = 4'b0;
        enter = 1'b0;
        reset = 1'b1;
    endtask

    task automatic key(input int s);
        logic [3:0] k;
        k = 4'b0001 << s;
        step(k, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic [3:0] keys;
        logic       en;
        logic [2:0] st;
        logic [3:0] na, nb, hi, tu;
        logic       wi, eq, ack, rv;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{4'b0001, 1'b0, 3'd0, 4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{4'b0010, 1'b0, 3'd0, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{4'b0100, 1'b0, 3'd0, 4'd3, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{4'b1000, 1'b0, 3'd0, 4'd4, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{4'b0000, 1'b1, 3'd1, 4'd4, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{4'b0001, 1'b0, 3'd1, 4'd4, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{4'b0010, 1'b0, 3'd1, 4'd4, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{4'b0100, 1'b0, 3'd1, 4'd4, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{4'b1000, 1'b0, 3'd1, 4'd4, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{4'b0000, 1'b1, 3'd2, 4'd4, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{4'b0000, 1'b0, 3'd3, 4'd4, 4'd4, 4'd4, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{4'b0001, 1'b1, 3'd3, 4'd4, 4'd4, 4'd4, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};

        step(4'b0, 1'b0, 1'b0);
        step(4'b0, 1'b0, 1'b0);
        chk("rst_state", state, 0);
        chk("rst_key_ack", key_ack, 0);

        // Win on an exact four-symbol guess.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].keys, tbl[i].en, 1'b1);
            chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
            chk($sformatf("tbl%0d_numa", i), numa, tbl[i].na);
            chk($sformatf("tbl%0d_numb", i), numb, tbl[i].nb);
            chk($sformatf("tbl%0d_hits", i), hits, tbl[i].hi);
            chk($sformatf("tbl%0d_turn", i), turn, tbl[i].tu);
            chk($sformatf("tbl%0d_win", i), win, tbl[i].wi);
            chk($sformatf("tbl%0d_equal", i), equal, tbl[i].eq);
            chk($sformatf("tbl%0d_key_ack", i), key_ack, tbl[i].ack);
            chk($sformatf("tbl%0d_rv", i), result_valid, tbl[i].rv);
        end

        // Enter below MIN_LEN is ignored.
        step(4'b0, 1'b0, 1'b0);
        key(0); key(1); key(2);
        step(4'b0, 1'b1, 1'b1);
        chk("short_enter_state", state, 0);
        key(3);
        step(4'b0, 1'b1, 1'b1);
        chk("min_enter_state", state, 1);

        // MAX_LEN auto-commit; eighth key goes to the guess buffer.
        step(4'b0, 1'b0, 1'b0);
        for (int i = 0; i < MAX_LEN; i++) key(i % 4);
        chk("auto_state", state, 1);
        chk("auto_numa", numa, MAX_LEN);
        key(0);
        chk("eighth_numb", numb, 1);

        // Longer guess: smaller flag, miss, back to ENTER_B.
        step(4'b0, 1'b0, 1'b0);
        key(0); key(0); key(1); key(1);
        step(4'b0, 1'b1, 1'b1);
        key(0); key(0); key(1); key(1); key(2);
        step(4'b0, 1'b1, 1'b1);
        step(4'b0, 1'b0, 1'b1);
        chk("long_smaller", smaller, 1);
        chk("long_hits", hits, 4);
        chk("long_win", win, 0);
        chk("long_turn", turn, 1);
        chk("long_numb", numb, 0);
        chk("long_state", state, 1);

        // Three misses lose the game; later keys are ignored.
        step(4'b0, 1'b0, 1'b0);
        key(0); key(1); key(2); key(0);
        step(4'b0, 1'b1, 1'b1);
        for (int t = 1; t <= MAX_TURNS; t++) begin
            key(3); key(3); key(3); key(3);
            step(4'b0, 1'b1, 1'b1);
            step(4'b0, 1'b0, 1'b1);
            chk($sformatf("lose_turn%0d", t), turn, t);
        end
        chk("lose_flag", lose, 1);
        chk("lose_state", state, 3);
        key(1);
        chk("done_key_ack", key_ack, 0);

        // Simultaneous I2|I3 stores symbol 1; reset mid-guess clears outputs.
        step(4'b0, 1'b0, 1'b0);
        step(4'b0110, 1'b0, 1'b1);
        chk("prio_numa", numa, 1);
        key(0); key(0); key(0);
        step(4'b0, 1'b1, 1'b1);
        key(1); key(0);
        chk("mid_numb", numb, 2);
        step(4'b0, 1'b0, 1'b0);
        chk("rst_mid_state", state, 0);
        chk("rst_mid_numa", numa, 0);
        chk("rst_mid_numb", numb, 0);
        step(4'b0110, 1'b0, 1'b1);
        key(0); key(0); key(0);
        step(4'b0, 1'b1, 1'b1);
        key(1); key(0); key(0); key(0);
        step(4'b0, 1'b1, 1'b1);
        step(4'b0, 1'b0, 1'b1);
        chk("prio_win", win, 1);

        // Reset while in COMPARE: result never committed.
        step(4'b0, 1'b0, 1'b0);
        key(0); key(1); key(2); key(3);
        step(4'b0, 1'b1, 1'b1);
        key(0); key(1); key(2); key(3);
        step(4'b0, 1'b1, 1'b1);
        chk("pre_abort_state", state, 2);
        step(4'b0, 1'b0, 1'b0);
        chk("abort_rv", result_valid, 0);
        chk("abort_win", win, 0);
        chk("abort_hits", hits, 0);

        // Randomized play against the model.
        step(4'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] k;
            bit en, rst;
            rst = ($urandom_range(0, 99) >= 2);
            k   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            en  = ($urandom_range(0, 3) == 0);
            step(k, en, rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
